// File: rtl/noc_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_port_pkg
//  Description : Connector slice layout shared by port endpoints, routers
//                and connector benches. A slice is {ready, valid, data}.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_port_pkg;

  // Default payload width of one flit
  localparam int DATA_SIZE_DEF = 37;

  // Slice width for a given payload width: data + valid + ready
  function automatic int port_size(input int data_size);
    return data_size + 2;
  endfunction

  // Position of the valid flag inside a slice
  function automatic int valid_bit(input int data_size);
    return data_size;
  endfunction

  // Position of the ready flag inside a slice
  function automatic int ready_bit(input int data_size);
    return data_size + 1;
  endfunction

  // Constants for the default flit width
  localparam int VALID_BIT     = DATA_SIZE_DEF;
  localparam int READY_BIT     = DATA_SIZE_DEF + 1;
  localparam int PORT_SIZE_DEF = DATA_SIZE_DEF + 2;

endpackage : noc_port_pkg
`default_nettype wire

// File: rtl/port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : port_fifo
//  Description : Synchronous FIFO with full/empty/count status. Push on full
//                and pop on empty are ignored. Head is a combinational read.
//  Revision    : 1.0 - initial release
// ============================================================================
module port_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage array; contents become unreachable on reset via the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally modulo the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule : port_fifo
`default_nettype wire

// File: rtl/port_link.sv
`default_nettype none
// ============================================================================
//  Module      : port_link
//  Description : Per-port link endpoint. TX FIFO plus registered output
//                stage toward the connector, RX FIFO absorbing peer words,
//                registered ready derived from next RX occupancy, and
//                wrapping transfer counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module port_link
  import noc_port_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int PORT_SIZE  = port_size(DATA_SIZE),
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PORT_SIZE-1:0] port_o,
  input  logic [PORT_SIZE-1:0] port_i,
  input  logic [DATA_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [CNT_W-1:0]     tx_cnt,
  output logic [CNT_W-1:0]     rx_cnt
);

  localparam int VB = valid_bit(DATA_SIZE);
  localparam int RB = ready_bit(DATA_SIZE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Registered state
  logic                 r_up;
  logic                 r_out_valid;
  logic [DATA_SIZE-1:0] r_out_data;
  logic                 r_ready;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic [CNT_W-1:0]     r_rx_cnt;

  // Connector fields
  logic                 w_peer_ready;
  logic                 w_peer_valid;
  logic [DATA_SIZE-1:0] w_peer_data;

  // TX path
  logic                 w_xfer;
  logic                 w_tx_accept;
  logic                 w_out_load;
  logic                 w_bypass;
  logic                 w_tx_push;
  logic                 w_tx_pop;
  logic [DATA_SIZE-1:0] w_tx_head;
  logic                 w_tx_full;
  logic                 w_tx_empty;
  logic [CW-1:0]        w_tx_count;

  // RX path
  logic                 w_acc;
  logic                 w_rx_pop;
  logic [DATA_SIZE-1:0] w_rx_head;
  logic                 w_rx_full;
  logic                 w_rx_empty;
  logic [CW-1:0]        w_rx_count;
  logic [CW-1:0]        w_rx_next;

  logic                 w_unused_ok;

  assign w_peer_ready = port_i[RB];
  assign w_peer_valid = port_i[VB];
  assign w_peer_data  = port_i[DATA_SIZE-1:0];

  // Both ends see the same wires, so these agree with the peer's view
  assign w_xfer = r_out_valid & w_peer_ready;
  assign w_acc  = w_peer_valid & r_ready;

  // TX steering: bypass the FIFO only when it holds nothing older
  assign tx_ready    = r_up & ~w_tx_full;
  assign w_tx_accept = tx_valid & tx_ready;
  assign w_out_load  = ~r_out_valid | w_xfer;
  assign w_bypass    = w_tx_accept & w_tx_empty & w_out_load;
  assign w_tx_push   = w_tx_accept & ~w_bypass;
  assign w_tx_pop    = w_out_load & ~w_tx_empty;

  port_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_tx_push),
    .push_data (tx_data),
    .pop       (w_tx_pop),
    .pop_data  (w_tx_head),
    .full      (w_tx_full),
    .empty     (w_tx_empty),
    .count     (w_tx_count)
  );

  // RX side: head is gated so stale storage never shows after reset
  assign w_rx_pop  = rx_valid & rx_ready;
  assign rx_valid  = ~w_rx_empty;
  assign rx_data   = rx_valid ? w_rx_head : '0;
  assign w_rx_next = w_rx_count + CW'(w_acc) - CW'(w_rx_pop);

  port_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_acc),
    .push_data (w_peer_data),
    .pop       (w_rx_pop),
    .pop_data  (w_rx_head),
    .full      (w_rx_full),
    .empty     (w_rx_empty),
    .count     (w_rx_count)
  );

  // Status bits not needed by the steering logic
  assign w_unused_ok = ^{w_tx_count, w_rx_full};

  assign port_o = {r_ready, r_out_valid, r_out_data};
  assign tx_cnt = r_tx_cnt;
  assign rx_cnt = r_rx_cnt;

  // Holds tx_ready low during reset and releases it one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_up <= 1'b0;
    end else begin
      r_up <= 1'b1;
    end
  end

  // Output register: FIFO head has priority, then bypassed local push
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_out_load) begin
      if (!w_tx_empty) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_tx_head;
      end else if (w_tx_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= tx_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Ready advertises room for one more word after this edge's accept/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_rx_next < CW'(FIFO_DEPTH));
    end
  end

  // Wrapping transfer statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
      end
      if (w_acc) begin
        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      end
    end
  end

endmodule : port_link
`default_nettype wire
